id_ex_pipe: RTL
===============

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 The module SHALL have parameter DATA_W, default 48, width of operand/immediate fields.
REQ-002 The module SHALL have parameter RA_W, default 4, width of destination-register and opcode fields.
REQ-003 The module SHALL have parameter CTRL_W, default 12, width of the packed control bundle.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  decode stage presents a valid instruction.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 in_srca, in_srcb, in_imm  input  DATA_W each  operand A, operand B, extended immediate.
REQ-009 in_wa3, in_opcode  input  RA_W each  destination register, opcode.
REQ-010 in_ctrl  input  CTRL_W  control bundle (regWrite, memWrite, flagUpdate, aluControl, ...).
REQ-011 flush  input  1  synchronous kill of all held and incoming instructions.
REQ-012 out_valid  output  1  execute stage is presented a valid instruction.
REQ-013 out_ready  input  1  execute stage consumes the presented instruction.
REQ-014 out_srca, out_srcb, out_imm, out_wa3, out_opcode, out_ctrl  output  widths as inputs  registered payload.
REQ-015 bubble_cnt  output  16  saturating count of cycles with out_valid=0.

Function
REQ-016 Storage SHALL be two entries: MAIN (drives outputs) and SKID (overflow), each a valid bit plus full payload.
REQ-017 in_ready SHALL equal NOT SKID.valid, taken directly from a register (no combinational path from out_ready).
REQ-018 Input transfer SHALL occur when in_valid=1 and in_ready=1; output transfer when out_valid=1 and out_ready=1.
REQ-019 out_valid SHALL equal MAIN.valid; out payload fields SHALL equal MAIN payload.
REQ-020 out_ctrl SHALL be forced to all-zero whenever out_valid=0, so a bubble never writes registers, memory or flags.
REQ-021 Latency SHALL be one cycle: an input accepted at edge N with MAIN empty or draining appears on outputs after edge N.
REQ-022 MAIN update: if MAIN empty or output transfer occurs, MAIN SHALL load SKID if SKID valid, else the input transfer if any, else become empty.
REQ-023 SKID update: an input transfer while MAIN stays occupied (no output transfer) SHALL load SKID; SKID SHALL empty when it moves into MAIN.
REQ-024 Order SHALL be preserved: SKID content always precedes any newer input.
REQ-025 With out_ready held 1, throughput SHALL be one instruction per cycle and SKID SHALL never fill.
REQ-026 flush=1 SHALL clear MAIN.valid and SKID.valid at the next edge and drop any same-cycle input transfer; flush has priority over all other updates.
REQ-027 Payload registers of an entry SHALL hold their value when not loaded (only valid bits are cleared by flush).
REQ-028 bubble_cnt SHALL increment by 1 each edge where out_valid=0, and SHALL saturate at 16'hFFFF.
REQ-029 Simultaneous input and output transfer with SKID empty SHALL replace MAIN with the input, SKID unchanged.

Reset
REQ-030 While rst=0, MAIN.valid, SKID.valid SHALL be 0, all payload registers 0, bubble_cnt 0, hence out_valid=0, out_ctrl=0, in_ready=1.
REQ-031 Reset assertion mid-transfer SHALL take effect immediately (asynchronously), discarding held instructions; first edge after release behaves as empty stage.

Verification
REQ-032 Streaming: out_ready=1, 4 back-to-back inputs opcode 1..4 -> out_opcode 1,2,3,4 on consecutive cycles, in_ready stays 1, bubble_cnt unchanged.
REQ-033 Backpressure: MAIN holds opcode 5, out_ready=0, input opcode 6 accepted -> in_ready=0 next cycle; out_ready=1 -> out 5 then 6, in_ready returns 1 after SKID drains.
REQ-034 Flush: MAIN=7, SKID=8, flush=1 with in_valid=1 opcode 9 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; opcode 9 never appears.
REQ-035 Bubble gating: in_valid=0 for 3 cycles with prior in_ctrl=12'hFFF -> out_ctrl=0 throughout, bubble_cnt +3.
REQ-036 Saturation: force 70000 idle cycles -> bubble_cnt=16'hFFFF and remains so.
REQ-037 Async reset: rst=0 between edges with both entries full -> out_valid=0, in_ready=1 before next edge; after release, input opcode 3 appears after one edge.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with a two-entry (main + skid) buffer so that in_ready is registered.
// Bubbles present an all-zero control bundle; bubble_cnt counts idle output cycles.
module id_ex_pipe #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned RA_W   = 4,
    parameter int unsigned CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_srca,
    input  logic [DATA_W-1:0] in_srcb,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [RA_W-1:0]   in_wa3,
    input  logic [RA_W-1:0]   in_opcode,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_srca,
    output logic [DATA_W-1:0] out_srcb,
    output logic [DATA_W-1:0] out_imm,
    output logic [RA_W-1:0]   out_wa3,
    output logic [RA_W-1:0]   out_opcode,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [15:0]       bubble_cnt
);

    localparam int unsigned PayW = 3 * DATA_W + 2 * RA_W + CTRL_W;

    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [PayW-1:0] main_pay_q, main_pay_d;
    logic [PayW-1:0] skid_pay_q, skid_pay_d;
    logic [15:0]     bubble_cnt_q, bubble_cnt_d;

    logic [PayW-1:0]   in_pay;
    logic [CTRL_W-1:0] main_ctrl;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;

    assign in_pay = {in_srca, in_srcb, in_imm, in_wa3, in_opcode, in_ctrl};

    assign in_ready  = ~skid_valid_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid_q & out_ready;
    assign main_load = ~main_valid_q | out_xfer;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pay_d   = main_pay_q;
        skid_valid_d = skid_valid_q;
        skid_pay_d   = skid_pay_q;

        if (flush) begin
            // Payloads are left untouched; only occupancy is cleared.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_load) begin
            // A full skid blocks in_ready, so no input can arrive alongside it.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_pay_d   = skid_pay_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_valid_d = 1'b1;
                main_pay_d   = in_pay;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_pay_d   = in_pay;
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!main_valid_q && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_pay_q   <= '0;
            skid_pay_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_pay_q   <= main_pay_d;
            skid_pay_q   <= skid_pay_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign {out_srca, out_srcb, out_imm, out_wa3, out_opcode, main_ctrl} = main_pay_q;

    assign out_valid  = main_valid_q;
    assign out_ctrl   = main_valid_q ? main_ctrl : '0;
    assign bubble_cnt = bubble_cnt_q;

endmodule
